// File: rtl/pio_pkg.sv
// Shared definitions for the pulse-capable output PIO.
//   ADDR_*        : word addresses of the eight slave registers
//   BUSY_BIT/DONE_BIT : bit positions inside the STATUS register
//   pulse_state_e : pulse timer state (IDLE when count is 0, BUSY otherwise)
package pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
  localparam logic [2:0] ADDR_PULSE     = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;
  localparam logic [2:0] ADDR_IRQ_EN    = 3'd7;

  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse down-counter.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : start/retrigger, count <= len (takes priority over abort)
//   abort       : force count to 0 without signalling completion
//   len         : reload value
//   busy        : count != 0
//   count       : remaining cycles of the current pulse
//   done_pulse  : single-cycle strobe on the natural 1 -> 0 transition
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | count == 0, no pulse in progress
// ST_BUSY | count != 0, pulse active, decrements each cycle
module pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             done_pulse
);
  import pio_pkg::*;

  logic [CNT_W-1:0] count_nxt;
  pulse_state_e     state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  always_comb begin
    count_nxt = count;
    if (load)                count_nxt = len;
    else if (abort)          count_nxt = '0;
    else if (count != '0)    count_nxt = count - CNT_W'(1);
  end

  // A retrigger or abort on the last busy cycle suppresses completion.
  always_comb begin
    state      = (count != '0) ? ST_BUSY : ST_IDLE;
    busy       = (state == ST_BUSY);
    done_pulse = (state == ST_BUSY) && (count == CNT_W'(1)) && !load && !abort;
  end

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear/toggle and a one-shot pulse overlay.
//   clk, reset  : clock, asynchronous active-high reset
//   address     : word address (see pio_pkg ADDR_*)
//   chipselect, write_n, writedata : slave write port
//   readdata    : combinational read mux, zero wait states
//   out_port    : data_out OR'ed with the pulse mask while a pulse runs
//   irq         : registered done & irq_en
module pio_out_pulse #(
  parameter int                WIDTH         = 8,
  parameter int                CNT_W         = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
  parameter int unsigned       PULSE_DEFAULT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);
  import pio_pkg::*;

  logic             wr;
  logic [WIDTH-1:0] wd_mask;
  logic             pulse_sel;
  logic             len_ok;
  logic             load;
  logic             abort;
  logic             busy;
  logic             done_pulse;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] pulse_mask;
  logic [CNT_W-1:0] pulse_len;
  logic             done;
  logic             irq_en;
  logic [63:0]      status_wide;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd_mask   = writedata[WIDTH-1:0];
  assign pulse_sel = wr && (address == ADDR_PULSE);
  // A zero PULSE_LEN makes PULSE writes a no-op, aborts included.
  assign len_ok    = (pulse_len != '0);
  assign load      = pulse_sel && len_ok && (wd_mask != '0);
  assign abort     = pulse_sel && len_ok && (wd_mask == '0) && busy;
  assign unused_wd = ^writedata;

  pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .abort      (abort),
    .len        (pulse_len),
    .busy       (busy),
    .count      (count),
    .done_pulse (done_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= RESET_VALUE;
      pulse_len  <= CNT_W'(PULSE_DEFAULT);
      pulse_mask <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA:      data_out  <= wd_mask;
          ADDR_SET:       data_out  <= data_out | wd_mask;
          ADDR_CLR:       data_out  <= data_out & ~wd_mask;
          ADDR_TOGGLE:    data_out  <= data_out ^ wd_mask;
          ADDR_PULSE_LEN: pulse_len <= writedata[CNT_W-1:0];
          ADDR_IRQ_EN:    irq_en    <= writedata[0];
          default: ;
        endcase
      end

      if (load)                     pulse_mask <= wd_mask;
      else if (abort || done_pulse) pulse_mask <= '0;

      // Completion beats a same-cycle software clear.
      if (done_pulse)
        done <= 1'b1;
      else if (wr && (address == ADDR_STATUS) && writedata[DONE_BIT])
        done <= 1'b0;

      irq <= done & irq_en;
    end
  end

  assign out_port = data_out | (busy ? pulse_mask : '0);

  always_comb begin
    readdata    = '0;
    status_wide = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0] = data_out;
      ADDR_PULSE_LEN: readdata[CNT_W-1:0] = pulse_len;
      ADDR_PULSE:     readdata[WIDTH-1:0] = pulse_mask;
      ADDR_STATUS: begin
        status_wide[CNT_W+1:2] = count;
        status_wide[DONE_BIT]  = done;
        status_wide[BUSY_BIT]  = busy;
        readdata               = status_wide[31:0];
      end
      ADDR_IRQ_EN:    readdata[0] = irq_en;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pio_out_pulse.sv
module tb_pio_out_pulse;

  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  pio_out_pulse #(
    .WIDTH         (8),
    .CNT_W         (16),
    .RESET_VALUE   (RV),
    .PULSE_DEFAULT (1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a pulse is described by the absolute cycle at which it ends.
  int unsigned cyc;
  int unsigned pulse_end;
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [15:0] m_len;
  logic        m_done;
  logic        m_irq_en;
  logic        m_irq;

  function automatic logic m_busy();
    return cyc < pulse_end;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    int unsigned rem;
    r = 32'd0;
    rem = m_busy() ? (pulse_end - cyc) : 0;
    case (a)
      3'd0: r[7:0]  = m_data;
      3'd4: r[15:0] = m_len;
      3'd5: r[7:0]  = m_busy() ? m_mask : 8'd0;
      3'd6: r = {14'd0, rem[15:0], m_done, m_busy()};
      3'd7: r[0] = m_irq_en;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] m_out();
    return m_data | (m_busy() ? m_mask : 8'd0);
  endfunction

  task automatic model_reset();
    cyc = 0; pulse_end = 0;
    m_data = RV; m_mask = 8'd0; m_len = 16'd1000;
    m_done = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    logic wr_now, busy_old, touched, done_set, clr, irq_next;
    logic [7:0] wd8;
    wr_now = chipselect & ~write_n;
    busy_old = m_busy();
    touched = 1'b0; done_set = 1'b0; clr = 1'b0;
    wd8 = writedata[7:0];
    irq_next = m_done & m_irq_en;
    if (wr_now) begin
      case (address)
        3'd0: m_data = wd8;
        3'd1: m_data = m_data | wd8;
        3'd2: m_data = m_data & ~wd8;
        3'd3: m_data = m_data ^ wd8;
        3'd4: m_len = writedata[15:0];
        3'd5: begin
          if (m_len != 16'd0) begin
            if (wd8 != 8'd0) begin
              pulse_end = cyc + 1 + m_len; m_mask = wd8; touched = 1'b1;
            end else if (busy_old) begin
              pulse_end = cyc + 1; m_mask = 8'd0; touched = 1'b1;
            end
          end
        end
        3'd6: clr = writedata[1];
        default: m_irq_en = writedata[0];
      endcase
    end
    if (busy_old && !touched && (cyc + 1 == pulse_end)) done_set = 1'b1;
    if (done_set)  m_done = 1'b1;
    else if (clr)  m_done = 1'b0;
    m_irq = irq_next;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic check_all();
    chk("out_port", 32'(out_port), 32'(m_out()));
    chk("irq", 32'(irq), 32'(m_irq));
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("read%0d", a), readdata, m_read(3'(a)));
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      check_all();
    end
  endtask

  task automatic rd_const(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    int unsigned a;
    int unsigned d;

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    model_reset();
    #5;
    chk("rst_out", 32'(out_port), 32'hA5);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_const("rst_status", 3'd6, 32'd0);
    rd_const("rst_len", 3'd4, 32'd1000);
    @(negedge clk);
    reset = 1'b0;

    // data register and atomic ops
    wr(3'd0, 32'h0F); chk("data", 32'(out_port), 32'h0F);
    wr(3'd1, 32'hF0); chk("set", 32'(out_port), 32'hFF);
    wr(3'd2, 32'h03); chk("clr", 32'(out_port), 32'hFC);
    wr(3'd3, 32'h81); chk("toggle", 32'(out_port), 32'h7D);

    // basic pulse with interrupt
    wr(3'd4, 32'd5);
    wr(3'd7, 32'd1);
    wr(3'd0, 32'd0);
    wr(3'd5, 32'h01);
    chk("pulse_c1", 32'(out_port), 32'h01);
    for (int i = 2; i <= 5; i++) begin
      idle(1);
      chk("pulse_hi", 32'(out_port[0]), 32'd1);
    end
    idle(1);
    chk("pulse_lo", 32'(out_port), 32'd0);
    rd_const("done_set", 3'd6, 32'd2);
    chk("irq_lag", 32'(irq), 32'd0);
    idle(1);
    chk("irq_on", 32'(irq), 32'd1);
    wr(3'd6, 32'd2);
    rd_const("done_clr", 3'd6, 32'd0);
    idle(1);
    chk("irq_off", 32'(irq), 32'd0);

    // retrigger
    wr(3'd4, 32'd10);
    wr(3'd5, 32'h02);
    idle(3);
    wr(3'd5, 32'h04);
    chk("retrig", 32'(out_port), 32'h04);
    idle(9);
    chk("retrig_last", 32'(out_port), 32'h04);
    idle(1);
    chk("retrig_end", 32'(out_port), 32'h00);
    rd_const("retrig_done", 3'd6, 32'd2);
    wr(3'd6, 32'd2);

    // abort
    wr(3'd5, 32'h02);
    idle(3);
    wr(3'd5, 32'h00);
    chk("abort", 32'(out_port), 32'h00);
    idle(12);
    rd_const("abort_nodone", 3'd6, 32'd0);

    // zero length ignored, length change mid-pulse
    wr(3'd4, 32'd0);
    wr(3'd5, 32'hFF);
    chk("len0", 32'(out_port), 32'h00);
    rd_const("len0_idle", 3'd6, 32'd0);
    wr(3'd4, 32'd8);
    wr(3'd5, 32'h01);
    idle(2);
    wr(3'd4, 32'd3);
    idle(4);
    chk("len_keep", 32'(out_port), 32'h01);
    idle(1);
    chk("len_keep_end", 32'(out_port), 32'h00);
    wr(3'd6, 32'd2);

    // asynchronous reset mid-pulse
    wr(3'd4, 32'd6);
    wr(3'd5, 32'h10);
    idle(1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out", 32'(out_port), 32'hA5);
    rd_const("async_status", 3'd6, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    rd_const("post_rst_status", 3'd6, 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);

    // randomized traffic against the model
    wr(3'd7, 32'd1);
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        a = $urandom_range(0, 7);
        d = $urandom;
        if (a == 4) d = $urandom_range(0, 12);
        if (a == 5 && $urandom_range(0, 3) == 0) d = 32'd0;
        wr(3'(a), d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_out_pulse.md
Name: pio_out_pulse

Overview:
Parametrised Avalon-MM slave output PIO: next generation of the fixed-width output port. Adds WIDTH-bit output, atomic set/clear/toggle access and a hardware one-shot pulse timer with done interrupt. Sits on the Qsys system interconnect; out_port drives board LEDs, strobes or enables.

Parameters:
WIDTH, 8, output port width (1..32)
CNT_W, 16, pulse counter width (1..32)
RESET_VALUE, 0, data register value after reset (WIDTH bits)
PULSE_DEFAULT, 1000, PULSE_LEN value after reset (fits CNT_W)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address, zero wait states
out_port  out  WIDTH  data_out | pulse_mask (while busy)
irq  out  1  done & irq_en, registered

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Write strobe: wr = chipselect & ~write_n; all register updates occur on the posedge where wr=1, visible on out_port the following cycle.
- Register map (word address):
  0 DATA rw: data_out <= wd[WIDTH-1:0].
  1 SET w: data_out <= data_out | wd. Reads 0.
  2 CLR w: data_out <= data_out & ~wd. Reads 0.
  3 TOGGLE w: data_out <= data_out ^ wd. Reads 0.
  4 PULSE_LEN rw: CNT_W bits, upper bits read 0.
  5 PULSE w: start/abort pulse; reads pulse_mask.
  6 STATUS: read {remaining count at [CNT_W+1:2], done at bit1, busy at bit0}; write 1 to bit1 clears done.
  7 IRQ_EN rw: bit0 only.
- Unused readdata bits are 0. Reads have no side effects.
- Pulse timer:
  - States IDLE (count=0) / BUSY (count!=0); busy = (count!=0).
  - PULSE write with wd mask!=0 and PULSE_LEN!=0: pulse_mask <= wd, count <= PULSE_LEN. out_port bits in mask are high for exactly PULSE_LEN cycles, starting the cycle after the write.
  - Each BUSY cycle: count decrements. On transition 1->0: pulse_mask <= 0, done <= 1.
  - PULSE write while BUSY: retrigger; mask replaced, count reloaded, no done generated.
  - PULSE write with mask=0 while BUSY: abort; count <= 0, mask <= 0, done not set. With mask=0 while IDLE: no effect.
  - PULSE_LEN=0: PULSE write ignored entirely.
  - PULSE_LEN write during BUSY: affects only the next pulse.
  - Same-cycle done set and STATUS clear write: set wins.
- DATA/SET/CLR/TOGGLE never alter pulse state; the pulse overlay ORs over data_out.
- irq <= done & irq_en, registered, so it asserts one cycle after done/irq_en change.
- Reset (asynchronous, any time, including mid-pulse):
  - data_out=RESET_VALUE, PULSE_LEN=PULSE_DEFAULT, count=0, pulse_mask=0, done=0, irq_en=0, irq=0.
  - out_port=RESET_VALUE immediately.

Decomposition:
- Shared package pio_pkg: address constants ADDR_DATA..ADDR_IRQ_EN (3-bit), STATUS bit indices BUSY_BIT=0 and DONE_BIT=1.
- One natural sub-module: pio_pulse_timer.
  - Inputs: load, abort, len.
  - Outputs: busy, count, done_pulse.
  - Holds count and done-edge detection.
- Register file and read mux stay in the top level.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata@6=0, irq=0, readdata@4=1000.
- DATA=8'h0F, SET 8'hF0, CLR 8'h03, TOGGLE 8'h81 -> out_port sequence 0F, FF, FC, 7D, each one cycle after its write; reads of addresses 1-3 return 0.
- PULSE_LEN=5, IRQ_EN=1, DATA=0, PULSE=8'h01:
  - out_port[0]=1 for exactly 5 cycles.
  - STATUS busy for 5 cycles, then done=1.
  - irq=1 one cycle after done.
  - Writing STATUS=2 clears done; irq drops next cycle.
- PULSE_LEN=10, PULSE=8'h02, after 4 cycles PULSE=8'h04 -> bit1 drops and bit2 high for 10 further cycles; single done at end. Repeat with PULSE=0 at cycle 4 -> all low, done stays 0.
- PULSE_LEN=0 then PULSE=8'hFF -> no change on out_port, busy stays 0; PULSE_LEN=3 written mid-pulse of length 8 -> current pulse still 8 cycles.
- Assert reset at cycle 2 of a 6-cycle pulse -> out_port=RESET_VALUE asynchronously, count=0; after release, no done and no irq.
